exec_scoreboard: RTL

EXEC_SCOREBOARD -- requirements
Module: exec_scoreboard

---
 rtl/exec_pkg.sv | 22 ++
 rtl/exec_scoreboard_sb_slot.sv | 47 ++++
 rtl/exec_scoreboard.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/exec_pkg.sv
// Shared execution-unit types and constants.
// Slot record layout and the scoreboard's default geometry.
package exec_pkg;

    localparam int NSLOT_DEF = 4;
    localparam int LATW_DEF  = 7;
    localparam int NREG_DEF  = 32;
    localparam int REGW_DEF  = $clog2(NREG_DEF);

    localparam logic FILE_INT = 1'b0;
    localparam logic FILE_FP  = 1'b1;

    localparam logic [REGW_DEF-1:0] REG_ZERO = '0;

    typedef struct packed {
        logic                valid;
        logic [LATW_DEF-1:0] cnt;
        logic [REGW_DEF-1:0] rd;
        logic                fd;
    } slot_t;

endpackage

// File: rtl/exec_scoreboard_sb_slot.sv
// One in-flight operation slot: countdown plus destination register.
// Requests writeback once the result is due at the next edge.
module sb_slot
    import exec_pkg::*;
(
    input  logic                clk,
    input  logic                rstn,
    input  logic                clear,
    input  logic                grant,
    input  logic                load,
    input  logic [LATW_DEF-1:0] load_cnt,
    input  logic [REGW_DEF-1:0] load_rd,
    input  logic                load_fd,
    output logic                req,
    output slot_t               rec
);

    slot_t rec_q;
    slot_t rec_d;

    always_comb begin
        rec_d = rec_q;
        if (clear || grant) begin
            rec_d = '0;
        end else if (load) begin
            rec_d.valid = 1'b1;
            rec_d.cnt   = load_cnt;
            rec_d.rd    = load_rd;
            rec_d.fd    = load_fd;
        end else if (rec_q.valid && rec_q.cnt != '0) begin
            rec_d.cnt = rec_q.cnt - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            rec_q <= '0;
        end else begin
            rec_q <= rec_d;
        end
    end

    // Asking at count 1 lets the registered writeback land L edges after issue.
    assign req = rec_q.valid && (rec_q.cnt <= LATW_DEF'(1));
    assign rec = rec_q;

endmodule

// File: rtl/exec_scoreboard.sv
// Register scoreboard for multi-cycle ops: busy bits per file,
// NSLOT countdown slots and a single registered writeback port.
module exec_scoreboard
    import exec_pkg::*;
#(
    parameter int NSLOT = NSLOT_DEF,
    parameter int LATW  = LATW_DEF,
    parameter int NREG  = NREG_DEF
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     issue_valid,
    output logic                     issue_ready,
    input  logic                     issue_writes,
    input  logic [$clog2(NREG)-1:0]  issue_rd,
    input  logic [$clog2(NREG)-1:0]  issue_rs,
    input  logic [$clog2(NREG)-1:0]  issue_rt,
    input  logic                     issue_fd,
    input  logic                     issue_fs,
    input  logic                     issue_ft,
    input  logic [LATW-1:0]          issue_lat,
    input  logic                     flush,
    output logic                     wb_valid,
    output logic [$clog2(NREG)-1:0]  wb_rd,
    output logic                     wb_fd,
    output logic [$clog2(NSLOT)-1:0] wb_slot,
    output logic [$clog2(NSLOT):0]   inflight,
    output logic                     idle
);

    localparam int RW = $clog2(NREG);
    localparam int SW = $clog2(NSLOT);
    localparam int CW = SW + 1;

    slot_t            rec [NSLOT];
    logic [NSLOT-1:0] req;
    logic [NSLOT-1:0] load;
    logic [NSLOT-1:0] grant;

    logic [NREG-1:0] busy_int_q, busy_int_d;
    logic [NREG-1:0] busy_fp_q, busy_fp_d;

    logic          wb_valid_q, wb_valid_d;
    logic [RW-1:0] wb_rd_q, wb_rd_d;
    logic          wb_fd_q, wb_fd_d;
    logic [SW-1:0] wb_slot_q, wb_slot_d;

    logic          wr_eff;
    logic          rs_busy, rt_busy, rd_busy;
    logic          free_any, req_any;
    logic [SW-1:0] free_idx, win_idx;
    logic          accept;
    logic [CW-1:0] inflight_c;

    // Integer r0 is hard-wired, so writing it is a no-op.
    assign wr_eff = issue_writes &&
                    !(issue_fd == FILE_INT && issue_rd == REG_ZERO);

    assign rs_busy = issue_fs ? busy_fp_q[issue_rs] : busy_int_q[issue_rs];
    assign rt_busy = issue_ft ? busy_fp_q[issue_rt] : busy_int_q[issue_rt];
    assign rd_busy = issue_fd ? busy_fp_q[issue_rd] : busy_int_q[issue_rd];

    always_comb begin
        free_any   = 1'b0;
        free_idx   = '0;
        req_any    = 1'b0;
        win_idx    = '0;
        inflight_c = '0;
        for (int i = NSLOT - 1; i >= 0; i--) begin
            if (!rec[i].valid) begin
                free_any = 1'b1;
                free_idx = SW'(i);
            end
            if (req[i]) begin
                req_any = 1'b1;
                win_idx = SW'(i);
            end
            inflight_c = inflight_c + CW'(rec[i].valid);
        end
    end

    assign issue_ready = rstn && !flush && !rs_busy && !rt_busy &&
                         !(wr_eff && (rd_busy || !free_any));

    assign accept = issue_valid && issue_ready && wr_eff;
    assign load   = NSLOT'(accept) << free_idx;
    assign grant  = NSLOT'(req_any) << win_idx;

    for (genvar g = 0; g < NSLOT; g++) begin : g_slot
        sb_slot u_slot (
            .clk      (clk),
            .rstn     (rstn),
            .clear    (flush),
            .grant    (grant[g]),
            .load     (load[g]),
            .load_cnt (issue_lat),
            .load_rd  (issue_rd),
            .load_fd  (issue_fd),
            .req      (req[g]),
            .rec      (rec[g])
        );
    end

    always_comb begin
        busy_int_d = busy_int_q;
        busy_fp_d  = busy_fp_q;
        if (req_any) begin
            if (rec[win_idx].fd) busy_fp_d[rec[win_idx].rd] = 1'b0;
            else                 busy_int_d[rec[win_idx].rd] = 1'b0;
        end
        if (accept) begin
            if (issue_fd) busy_fp_d[issue_rd] = 1'b1;
            else          busy_int_d[issue_rd] = 1'b1;
        end
        if (flush) begin
            busy_int_d = '0;
            busy_fp_d  = '0;
        end
    end

    always_comb begin
        wb_valid_d = req_any && !flush;
        wb_rd_d    = wb_rd_q;
        wb_fd_d    = wb_fd_q;
        wb_slot_d  = wb_slot_q;
        if (req_any) begin
            wb_rd_d   = rec[win_idx].rd;
            wb_fd_d   = rec[win_idx].fd;
            wb_slot_d = win_idx;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            busy_int_q <= '0;
            busy_fp_q  <= '0;
            wb_valid_q <= 1'b0;
            wb_rd_q    <= '0;
            wb_fd_q    <= 1'b0;
            wb_slot_q  <= '0;
        end else begin
            busy_int_q <= busy_int_d;
            busy_fp_q  <= busy_fp_d;
            wb_valid_q <= wb_valid_d;
            wb_rd_q    <= wb_rd_d;
            wb_fd_q    <= wb_fd_d;
            wb_slot_q  <= wb_slot_d;
        end
    end

    assign wb_valid = wb_valid_q;
    assign wb_rd    = wb_rd_q;
    assign wb_fd    = wb_fd_q;
    assign wb_slot  = wb_slot_q;
    assign inflight = inflight_c;
    assign idle     = (inflight_c == '0) && !wb_valid_q;

endmodule
